// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpu_pkg
// Purpose  : Shared FPU types and constants: multiplier response payload and
//            IEEE-754 rounding-mode encodings.
// Revision : 1.0 - initial release
// ============================================================================
package fpu_pkg;

    // One multiplier result as it is stored in a response FIFO
    typedef struct packed {
        logic [31:0] z;
        logic        ovrf;
        logic        udrf;
    } fpu_mul_rsp_t;

    // Rounding modes
    localparam logic [2:0] RNE = 3'b000;  // nearest, ties to even
    localparam logic [2:0] RTZ = 3'b001;  // toward zero
    localparam logic [2:0] RDN = 3'b010;  // toward -inf
    localparam logic [2:0] RUP = 3'b011;  // toward +inf
    localparam logic [2:0] RMM = 3'b100;  // nearest, ties away from zero

endpackage
`default_nettype wire

// File: rtl/fpu_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fpu_rsp_fifo
// Purpose  : Per-requester response FIFO holding multiplier results. Exposes
//            its occupancy so the arbiter can compute credits. Head data reads
//            as zero while empty.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_rsp_fifo
    import fpu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int OW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  fpu_mul_rsp_t  i_wdata,
    input  logic          i_pop,
    output fpu_mul_rsp_t  o_rdata,
    output logic          o_valid,
    output logic [OW-1:0] o_occ
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fpu_mul_rsp_t  r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [OW-1:0] r_occ;
    logic          w_pop;

    // Pointers wrap at DEPTH, which need not be a power of two
    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_valid = (r_occ != '0);
    assign o_occ   = r_occ;
    assign w_pop   = i_pop && o_valid;
    assign o_rdata = o_valid ? r_mem[r_rd] : '0;

    // Storage array; the credit scheme upstream guarantees no push when full
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr] <= i_wdata;
        end
    end

    // Pointer and occupancy bookkeeping; push+pop together keeps occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_occ <= '0;
        end else begin
            if (i_push) r_wr <= f_next(r_wr);
            if (w_pop)  r_rd <= f_next(r_rd);
            r_occ <= r_occ + OW'(i_push) - OW'(w_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/fpu_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fpu_mul_arbiter
// Purpose  : Shares one fixed-latency pipelined FP32 multiplier among NREQ
//            requesters. Credit-gated grant, tag pipeline matched to LAT and
//            one response FIFO per requester; the multiplier never stalls.
// Config   : FPU_MUL_ARB_RR_EN defined -> round-robin arbitration,
//            otherwise fixed priority (lowest index wins).
// Revision : 1.0 - initial release
// ============================================================================
module fpu_mul_arbiter
    import fpu_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int LAT    = 3,
    parameter int RDEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*32-1:0] req_x,
    input  logic [NREQ*32-1:0] req_y,
    input  logic [NREQ*3-1:0]  req_rmode,
    output logic               mul_valid,
    output logic [31:0]        mul_x,
    output logic [31:0]        mul_y,
    output logic [2:0]         mul_rmode,
    input  logic [31:0]        mul_z,
    input  logic               mul_ovrf,
    input  logic               mul_udrf,
    output logic [NREQ-1:0]    rsp_valid,
    input  logic [NREQ-1:0]    rsp_ready,
    output logic [NREQ*32-1:0] rsp_z,
    output logic [NREQ-1:0]    rsp_ovrf,
    output logic [NREQ-1:0]    rsp_udrf
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(RDEPTH + 1);

    logic [LAT-1:0]  r_tag_v;
    logic [IDW-1:0]  r_tag_id   [LAT];
    logic [CW-1:0]   r_inflight [NREQ];
    logic [CW-1:0]   w_occ      [NREQ];
    fpu_mul_rsp_t    w_head     [NREQ];
    fpu_mul_rsp_t    w_mul_rsp;
    logic [NREQ-1:0] w_elig;
    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_gid;
    logic [IDW-1:0]  w_cand;
    logic            w_found;
    logic            w_ret_v;
    logic [IDW-1:0]  w_ret_id;

`ifdef FPU_MUL_ARB_RR_EN
    logic [IDW-1:0]  r_rr_ptr;
`endif

    assign w_ret_v   = r_tag_v[LAT-1];
    assign w_ret_id  = r_tag_id[LAT-1];
    assign w_mul_rsp = {mul_z, mul_ovrf, mul_udrf};

    // Eligibility: valid request and room reserved for its result
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            w_elig[i] = req_valid[i] &&
                        (({1'b0, w_occ[i]} + {1'b0, r_inflight[i]}) < (CW + 1)'(RDEPTH));
        end
    end

    // Grant: first eligible requester in search order, none while in reset
    always_comb begin
        w_grant = '0;
        w_gid   = '0;
        w_cand  = '0;
        w_found = 1'b0;
        if (!rst) begin
            for (int k = 0; k < NREQ; k++) begin
`ifdef FPU_MUL_ARB_RR_EN
                w_cand = IDW'((int'(r_rr_ptr) + k) % NREQ);
`else
                w_cand = IDW'(k);
`endif
                if (!w_found && w_elig[w_cand]) begin
                    w_found = 1'b1;
                    w_gid   = w_cand;
                end
            end
            if (w_found) begin
                w_grant[w_gid] = 1'b1;
            end
        end
    end

    assign req_ready = w_grant;
    assign mul_valid = w_found;
    assign mul_x     = w_found ? req_x[32*int'(w_gid) +: 32]   : '0;
    assign mul_y     = w_found ? req_y[32*int'(w_gid) +: 32]   : '0;
    assign mul_rmode = w_found ? req_rmode[3*int'(w_gid) +: 3] : '0;

`ifdef FPU_MUL_ARB_RR_EN
    // Round-robin pointer moves just past the winner; holds when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_found) begin
            r_rr_ptr <= (w_gid == IDW'(NREQ - 1)) ? '0 : w_gid + 1'b1;
        end
    end
`endif

    // Owner tags travel alongside the multiplier pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_v <= '0;
            for (int k = 0; k < LAT; k++) r_tag_id[k] <= '0;
        end else begin
            r_tag_v[0]  <= w_found;
            r_tag_id[0] <= w_gid;
            for (int k = 1; k < LAT; k++) begin
                r_tag_v[k]  <= r_tag_v[k-1];
                r_tag_id[k] <= r_tag_id[k-1];
            end
        end
    end

    // Operations outstanding in the multiplier, per owner
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) r_inflight[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                r_inflight[i] <= r_inflight[i] + CW'(w_grant[i])
                               - CW'(w_ret_v && (w_ret_id == IDW'(i)));
            end
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_fifo
        fpu_rsp_fifo #(
            .DEPTH (RDEPTH),
            .OW    (CW)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .i_push  (w_ret_v && (w_ret_id == IDW'(gi))),
            .i_wdata (w_mul_rsp),
            .i_pop   (rsp_ready[gi]),
            .o_rdata (w_head[gi]),
            .o_valid (rsp_valid[gi]),
            .o_occ   (w_occ[gi])
        );
        assign rsp_z[32*gi +: 32] = w_head[gi].z;
        assign rsp_ovrf[gi]       = w_head[gi].ovrf;
        assign rsp_udrf[gi]       = w_head[gi].udrf;
    end

endmodule
`default_nettype wire

// File: tb/tb_fpu_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_mul_arbiter
// Purpose  : Self-checking bench for fpu_mul_arbiter with a behavioural
//            multiplier, a queue-based reference model and directed phases
//            followed by randomized traffic.
// Config   : FPU_MUL_ARB_RR_EN selects round-robin expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_mul_arbiter;
    import fpu_pkg::*;

    localparam int NREQ   = 2;
    localparam int LAT    = 3;
    localparam int RDEPTH = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_x;
    logic [NREQ*32-1:0] req_y;
    logic [NREQ*3-1:0]  req_rmode;
    logic               mul_valid;
    logic [31:0]        mul_x;
    logic [31:0]        mul_y;
    logic [2:0]         mul_rmode;
    logic [31:0]        mul_z;
    logic               mul_ovrf;
    logic               mul_udrf;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ-1:0]    rsp_ready;
    logic [NREQ*32-1:0] rsp_z;
    logic [NREQ-1:0]    rsp_ovrf;
    logic [NREQ-1:0]    rsp_udrf;

    int checks = 0;
    int errors = 0;

    fpu_mul_arbiter #(
        .NREQ   (NREQ),
        .LAT    (LAT),
        .RDEPTH (RDEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_rmode (req_rmode),
        .mul_valid (mul_valid),
        .mul_x     (mul_x),
        .mul_y     (mul_y),
        .mul_rmode (mul_rmode),
        .mul_z     (mul_z),
        .mul_ovrf  (mul_ovrf),
        .mul_udrf  (mul_udrf),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_z     (rsp_z),
        .rsp_ovrf  (rsp_ovrf),
        .rsp_udrf  (rsp_udrf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Simplified FP32 multiply (normals only): returns {z, ovrf, udrf}
    function automatic logic [33:0] fmul(input logic [31:0] x, input logic [31:0] y,
                                         input logic [2:0] rm);
        logic        s;
        int          e;
        logic [47:0] m;
        logic [22:0] f;
        logic        rb;
        s = x[31] ^ y[31];
        e = int'(x[30:23]) + int'(y[30:23]) - 127;
        m = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, y[22:0]};
        if (m[47]) begin
            e++;
            f  = m[46:24];
            rb = m[23];
        end else begin
            f  = m[45:23];
            rb = m[22];
        end
        if ((rm == RNE || rm == RMM) && rb) f = f + 23'd1;
        if (e >= 255) return {s, 8'hff, 23'd0, 1'b1, 1'b0};
        if (e <= 0)   return {s, 31'd0, 1'b0, 1'b1};
        return {s, e[7:0], f, 2'b00};
    endfunction

    // Behavioural multiplier: LAT-deep delay line; junk when nothing issued
    logic [33:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= mul_valid ? fmul(mul_x, mul_y, mul_rmode) : {$urandom, 2'($urandom)};
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign {mul_z, mul_ovrf, mul_udrf} = pipe[LAT-1];

    // Reference model: each issued op is outstanding until popped;
    // it becomes visible LAT+1 cycles after its issue cycle
    typedef struct {
        int          cyc;
        logic [33:0] r;
    } rec_t;

    rec_t mq [NREQ][$];
    int   cyc      = 0;
    int   rr       = 0;
    bit   prev_rst = 1'b0;

    initial begin
        forever begin
            int              gexp;
            logic [NREQ-1:0] gv;
            bit              ev;
            rec_t            rec;
            @(negedge clk);
            gexp = -1;
            if (!rst) begin
                for (int k = 0; k < NREQ; k++) begin
                    int idx;
`ifdef FPU_MUL_ARB_RR_EN
                    idx = (rr + k) % NREQ;
`else
                    idx = k;
`endif
                    if (gexp < 0 && req_valid[idx] && mq[idx].size() < RDEPTH) gexp = idx;
                end
            end
            gv = (gexp >= 0) ? (NREQ'(1) << gexp) : '0;
            check("req_ready", 64'(req_ready), 64'(gv));
            check("mul_valid", 64'(mul_valid), 64'(gexp >= 0));
            check("mul_x",     64'(mul_x),     (gexp >= 0) ? 64'(req_x[32*gexp +: 32]) : 64'd0);
            check("mul_y",     64'(mul_y),     (gexp >= 0) ? 64'(req_y[32*gexp +: 32]) : 64'd0);
            check("mul_rmode", 64'(mul_rmode), (gexp >= 0) ? 64'(req_rmode[3*gexp +: 3]) : 64'd0);

            for (int i = 0; i < NREQ; i++) begin
                ev = (mq[i].size() > 0) && (mq[i][0].cyc + LAT + 1 <= cyc);
                if (!(rst && !prev_rst)) begin
                    check("rsp_valid", 64'(rsp_valid[i]), 64'(ev));
                    if (ev) begin
                        check("rsp_data", {30'd0, rsp_z[32*i +: 32], rsp_ovrf[i], rsp_udrf[i]},
                              64'(mq[i][0].r));
                    end else if (prev_rst) begin
                        check("rsp_reset_data", {30'd0, rsp_z[32*i +: 32], rsp_ovrf[i], rsp_udrf[i]},
                              64'd0);
                    end
                end
                if (!rst && ev && rsp_ready[i]) void'(mq[i].pop_front());
            end

            if (rst) begin
                for (int i = 0; i < NREQ; i++) mq[i].delete();
                rr = 0;
            end else if (gexp >= 0) begin
                rec.cyc = cyc;
                rec.r   = fmul(req_x[32*gexp +: 32], req_y[32*gexp +: 32], req_rmode[3*gexp +: 3]);
                mq[gexp].push_back(rec);
                rr = (gexp + 1) % NREQ;
            end
            prev_rst = rst;
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed phases, then randomized traffic
    initial begin
        int              first;
        int              n0;
        int              n1;
        logic [NREQ-1:0] g [8];

        rst       = 1'b1;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        req_rmode = '0;
        rsp_ready = '0;

        check("pin_fmul_3x3", 64'(fmul(32'h40400000, 32'h40400000, RTZ)), {30'd0, 32'h41100000, 2'b00});
        check("pin_fmul_1x2", 64'(fmul(32'h3f800000, 32'h40000000, RNE)), {30'd0, 32'h40000000, 2'b00});

        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_mul_valid", 64'(mul_valid), 64'd0);
        tick();

        // Single op from requester 0
        req_valid        = 2'b01;
        req_x[31:0]      = 32'h40400000;
        req_y[31:0]      = 32'h40400000;
        req_rmode[2:0]   = RTZ;
        @(negedge clk);
        check("A_grant", 64'(req_ready), 64'b01);
        tick();
        req_valid = '0;
        first = -1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (rsp_valid[0] && first < 0) begin
                first = k;
                check("A_rsp_z", 64'(rsp_z[31:0]), 64'h41100000);
                check("A_flags", 64'({rsp_ovrf[0], rsp_udrf[0]}), 64'd0);
            end
            @(posedge clk);
            #1;
        end
        check("A_latency", 64'(first), 64'd4);
        rsp_ready = 2'b01;
        tick();
        rsp_ready = '0;
        tick();

        // Contention with both requesters always valid
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        req_x     = {32'h40000000, 32'h3fc00000};
        req_y     = {32'h40400000, 32'h40800000};
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            g[k] = req_ready;
            @(posedge clk);
            #1;
        end
        for (int k = 1; k < 8; k++) begin
`ifdef FPU_MUL_ARB_RR_EN
            check("B_alternate", 64'(g[k] ^ g[k-1]), 64'b11);
`else
            check("B_fixed_prio", 64'(g[k]), 64'b01);
`endif
        end
        req_valid = '0;
        repeat (15) tick();

        // Backpressure on requester 0, requester 1 keeps flowing
        rsp_ready = 2'b10;
        req_valid = 2'b11;
        n0 = 0;
        n1 = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            n0 += int'(req_ready[0]);
            n1 += int'(req_ready[1]);
            @(posedge clk);
            #1;
        end
        check("C_issues_r0", 64'(n0), 64'(RDEPTH));
        check("C_r1_progress", 64'(n1 > 0), 64'd1);
        req_valid = 2'b01;
        rsp_ready = 2'b01;
        @(negedge clk);
        check("C_no_credit_at_pop", 64'(req_ready[0]), 64'd0);
        tick();
        rsp_ready = '0;
        @(negedge clk);
        check("C_credit_after_pop", 64'(req_ready[0]), 64'd1);
        tick();
        req_valid = '0;
        rsp_ready = 2'b11;
        repeat (15) tick();

        // Reset with three operations in flight
        rsp_ready = '0;
        req_valid = 2'b11;
        repeat (3) tick();
        req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("E_rsp_cleared", 64'(rsp_valid), 64'd0);
        repeat (8) tick();
        @(negedge clk);
        check("E_stale_ignored", 64'(rsp_valid), 64'd0);
        tick();
        req_valid = 2'b01;
        n0 = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            n0 += int'(req_ready[0]);
            @(posedge clk);
            #1;
        end
        check("E_full_credit", 64'(n0), 64'(RDEPTH));
        req_valid = '0;
        rsp_ready = 2'b11;
        repeat (15) tick();

        // Randomized traffic with occasional reset
        for (int k = 0; k < 3000; k++) begin
            rst       = ($urandom_range(0, 299) == 0);
            req_valid = NREQ'($urandom);
            req_x     = {$urandom, $urandom};
            req_y     = {$urandom, $urandom};
            for (int i = 0; i < NREQ; i++) req_rmode[3*i +: 3] = 3'($urandom_range(0, 4));
            for (int i = 0; i < NREQ; i++) rsp_ready[i] = ($urandom_range(0, 3) != 0);
            tick();
        end
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = 2'b11;
        repeat (10) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
